// File: rtl/multicycle_main_decoder_if.sv
// Bundle between the multicycle main decoder and the datapath/conditional logic.
// The slave side is the decoder itself; the master side drives instruction
// fields and the memory-ready handshake and consumes the control requests.
interface multicycle_main_decoder_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd15;
  logic       mem_ready;

  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;
  logic       NoWrite;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic       illegal;

  modport master (
    output op, funct, rd15, mem_ready,
    input  PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, illegal
  );

  modport slave (
    input  op, funct, rd15, mem_ready,
    output PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, illegal
  );
endinterface

// File: rtl/multicycle_main_decoder.sv
// Multicycle main controller: sequences each instruction through fetch,
// decode, execute, memory and writeback, and issues the unconditioned write
// requests plus datapath steering selects.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 computed; wait for mem_ready
// DECODE   | read registers, PC+8 on ALU; dispatch on op
// MEMADR   | compute load/store address (base + immediate)
// MEMREAD  | load access at ALU result; wait for mem_ready
// MEMWB    | write loaded data to register file
// MEMWRITE | store access; MemW held until mem_ready
// EXECR    | data-processing with register operand B
// EXECI    | data-processing with immediate operand B
// ALUWB    | write ALU result to register file
// BRANCH   | PC <- PC+8+offset
module multicycle_main_decoder (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_main_decoder_if.slave      bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  state_t     state;
  state_t     state_nxt;
  // Low from reset assertion until the first rising edge after release, so
  // the first FETCH cycle is clock-aligned rather than starting mid-cycle.
  logic       run_q;

  logic [3:0] cmd;
  logic       s_bit;
  logic [2:0] alu_ctl;
  logic [1:0] flag_w;
  logic       no_write;

  assign cmd   = bus.funct[4:1];
  assign s_bit = bus.funct[0];

  // State register and run qualifier; reset returns to FETCH at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  // ALU command decode: operation, flag-update mask and CMP write suppression.
  always_comb begin
    alu_ctl  = ALU_ADD;
    flag_w   = 2'b00;
    no_write = 1'b0;
    case (cmd)
      4'b0100: begin alu_ctl = ALU_ADD; flag_w = {s_bit, s_bit}; end
      4'b0010: begin alu_ctl = ALU_SUB; flag_w = {s_bit, s_bit}; end
      4'b0000: begin alu_ctl = ALU_AND; flag_w = {s_bit, 1'b0}; end
      4'b1100: begin alu_ctl = ALU_ORR; flag_w = {s_bit, 1'b0}; end
      4'b1010: begin alu_ctl = ALU_SUB; flag_w = 2'b11; no_write = 1'b1; end
      default: begin alu_ctl = ALU_ADD; flag_w = 2'b00; end
    endcase
  end

  // Next-state logic; holds FETCH until the run qualifier is set.
  always_comb begin
    state_nxt = state;
    if (run_q) begin
      case (state)
        FETCH:    if (bus.mem_ready) state_nxt = DECODE;
        DECODE: begin
          case (bus.op)
            2'b01:   state_nxt = MEMADR;
            2'b00:   state_nxt = bus.funct[5] ? EXECI : EXECR;
            2'b11:   state_nxt = BRANCH;
            default: state_nxt = FETCH;
          endcase
        end
        MEMADR:   state_nxt = bus.funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (bus.mem_ready) state_nxt = MEMWB;
        MEMWB:    state_nxt = FETCH;
        MEMWRITE: if (bus.mem_ready) state_nxt = FETCH;
        EXECR:    state_nxt = ALUWB;
        EXECI:    state_nxt = ALUWB;
        ALUWB:    state_nxt = FETCH;
        BRANCH:   state_nxt = FETCH;
        default:  state_nxt = FETCH;
      endcase
    end
  end

  // Output decode from state; everything forced low while reset is asserted
  // or before the first post-reset edge.
  always_comb begin
    bus.PCS        = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.FlagW      = 2'b00;
    bus.NoWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.NextPC     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.illegal    = 1'b0;
    if (reset && run_q) begin
      case (state)
        FETCH: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.mem_ready;
          bus.NextPC    = bus.mem_ready;
        end
        DECODE: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.illegal   = (bus.op == 2'b10);
        end
        MEMADR: begin
          bus.ALUSrcB   = 2'b01;
        end
        MEMREAD: begin
          bus.AdrSrc    = 1'b1;
        end
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegW      = 1'b1;
          bus.PCS       = bus.rd15;
        end
        MEMWRITE: begin
          bus.AdrSrc    = 1'b1;
          bus.MemW      = 1'b1;
        end
        EXECR, EXECI: begin
          bus.ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
          bus.ALUControl = alu_ctl;
          bus.FlagW      = flag_w;
          bus.NoWrite    = no_write;
        end
        ALUWB: begin
          bus.ResultSrc  = 2'b00;
          bus.RegW       = 1'b1;
          bus.PCS        = bus.rd15;
          bus.ALUControl = alu_ctl;
          bus.FlagW      = flag_w;
          bus.NoWrite    = no_write;
        end
        BRANCH: begin
          bus.ALUSrcB   = 2'b01;
          bus.ResultSrc = 2'b10;
          bus.PCS       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_decoder.sv
// Self-checking bench for multicycle_main_decoder. Each instruction is turned
// into a per-cycle list of (mem_ready to drive, outputs expected) built from
// the instruction-level behaviour, then played against the DUT.
module tb_multicycle_main_decoder;

  typedef struct packed {
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       NoWrite;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic  mr;
    outs_t exp;
  } step_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  step_t plan[$];

  multicycle_main_decoder_if bus ();

  multicycle_main_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic outs_t observed();
    outs_t o;
    o.PCS        = bus.PCS;
    o.RegW       = bus.RegW;
    o.MemW       = bus.MemW;
    o.FlagW      = bus.FlagW;
    o.NoWrite    = bus.NoWrite;
    o.IRWrite    = bus.IRWrite;
    o.NextPC     = bus.NextPC;
    o.AdrSrc     = bus.AdrSrc;
    o.ALUSrcA    = bus.ALUSrcA;
    o.ALUSrcB    = bus.ALUSrcB;
    o.ResultSrc  = bus.ResultSrc;
    o.ALUControl = bus.ALUControl;
    o.illegal    = bus.illegal;
    return o;
  endfunction

  function automatic outs_t zero_o();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t fetch_o(input logic ready);
    outs_t o = '0;
    o.ALUSrcA   = 1'b1;
    o.ALUSrcB   = 2'b10;
    o.ResultSrc = 2'b10;
    o.IRWrite   = ready;
    o.NextPC    = ready;
    return o;
  endfunction

  // {ALUControl, FlagW, NoWrite} for a data-processing funct field.
  function automatic logic [5:0] dp_ref(input logic [5:0] f);
    logic [3:0] c;
    logic       s;
    c = f[4:1];
    s = f[0];
    if (c == 4'b1010) return {3'b001, 2'b11, 1'b0} | 6'b000001;
    if (c == 4'b0100) return {3'b000, s, s, 1'b0};
    if (c == 4'b0010) return {3'b001, s, s, 1'b0};
    if (c == 4'b0000) return {3'b010, s, 1'b0, 1'b0};
    if (c == 4'b1100) return {3'b011, s, 1'b0, 1'b0};
    return 6'b000000;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic mr, input outs_t e);
    step_t s;
    s.mr  = mr;
    s.exp = e;
    plan.push_back(s);
  endfunction

  // Expected cycle list for one instruction with given stall counts.
  function automatic void build_instr(input logic [1:0] op, input logic [5:0] f,
                                      input logic rd, input int fstall, input int mstall);
    outs_t e;
    logic [5:0] d;
    for (int i = 0; i < fstall; i++) push(1'b0, fetch_o(1'b0));
    push(1'b1, fetch_o(1'b1));
    e = fetch_o(1'b0);
    e.illegal = (op == 2'b10);
    push(rnd_bit(), e);
    case (op)
      2'b01: begin
        e = zero_o(); e.ALUSrcB = 2'b01;
        push(rnd_bit(), e);
        e = zero_o(); e.AdrSrc = 1'b1; e.MemW = ~f[0];
        for (int i = 0; i < mstall; i++) push(1'b0, e);
        push(1'b1, e);
        if (f[0]) begin
          e = zero_o(); e.ResultSrc = 2'b01; e.RegW = 1'b1; e.PCS = rd;
          push(rnd_bit(), e);
        end
      end
      2'b00: begin
        d = dp_ref(f);
        e = zero_o();
        e.ALUSrcB = f[5] ? 2'b01 : 2'b00;
        e.ALUControl = d[5:3]; e.FlagW = d[2:1]; e.NoWrite = d[0];
        push(rnd_bit(), e);
        e.ALUSrcB = 2'b00; e.RegW = 1'b1; e.PCS = rd;
        push(rnd_bit(), e);
      end
      2'b11: begin
        e = zero_o(); e.ALUSrcB = 2'b01; e.ResultSrc = 2'b10; e.PCS = 1'b1;
        push(rnd_bit(), e);
      end
      default: ;
    endcase
  endfunction

  // Plays the plan; entered and left just after a rising edge.
  task automatic run_plan(input string name, input int limit);
    step_t s;
    int n;
    n = 0;
    while (plan.size() > 0 && (limit < 0 || n < limit)) begin
      s = plan.pop_front();
      bus.mem_ready = s.mr;
      @(negedge clk);
      checks++;
      if (observed() !== s.exp) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", name, n, observed(), s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] f, input logic rd);
    bus.op = op; bus.funct = f; bus.rd15 = rd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    set_instr(2'b00, 6'b000000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== zero_o()) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", observed(), zero_o());
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== zero_o()) begin
      errors++;
      $display("FAIL reset_release_pre_edge: got %h expected %h", observed(), zero_o());
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (observed() !== fetch_o(1'b1)) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h expected %h", observed(), fetch_o(1'b1));
    end
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    set_instr(2'b00, 6'b001001, 1'b0);
    build_instr(2'b00, 6'b001001, 1'b0, 0, 0);
    run_plan("add", -1);
  endtask

  task automatic test_cmp();
    set_instr(2'b00, 6'b010100, 1'b1);
    build_instr(2'b00, 6'b010100, 1'b1, 1, 0);
    run_plan("cmp", -1);
  endtask

  task automatic test_ldr();
    set_instr(2'b01, 6'b000001, 1'b0);
    build_instr(2'b01, 6'b000001, 1'b0, 0, 2);
    run_plan("ldr_stall", -1);
  endtask

  task automatic test_branch_illegal();
    set_instr(2'b11, 6'b100000, 1'b0);
    build_instr(2'b11, 6'b100000, 1'b0, 0, 0);
    run_plan("branch", -1);
    set_instr(2'b10, 6'b000000, 1'b0);
    build_instr(2'b10, 6'b000000, 1'b0, 0, 0);
    run_plan("illegal", -1);
  endtask

  // Cycles from one IRWrite to the next with mem_ready tied high.
  task automatic measure(input string name, input logic [1:0] op,
                         input logic [5:0] f, input int exp_len);
    int n;
    set_instr(op, f, 1'b0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n = 0;
    do begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end while (bus.IRWrite !== 1'b1 && n < 20);
    checks++;
    if (n !== exp_len) begin
      errors++;
      $display("FAIL latency_%s: got %0d cycles expected %0d", name, n, exp_len);
    end
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    measure("dp",      2'b00, 6'b001000, 4);
    measure("load",    2'b01, 6'b000001, 5);
    measure("store",   2'b01, 6'b000000, 4);
    measure("branch",  2'b11, 6'b000000, 3);
    measure("illegal", 2'b10, 6'b000000, 2);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [5:0] f;
    logic       rd;
    logic [3:0] cmds [6];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 5)];
      rd = rnd_bit();
      set_instr(op, f, rd);
      build_instr(op, f, rd, $urandom_range(0, 2), $urandom_range(0, 2));
      run_plan("random", -1);
    end
  endtask

  task automatic test_str_reset();
    outs_t w;
    set_instr(2'b01, 6'b000000, 1'b0);
    build_instr(2'b01, 6'b000000, 1'b0, 0, 3);
    run_plan("str_pre_reset", 4);
    bus.mem_ready = 1'b0;
    #2;
    w = zero_o(); w.AdrSrc = 1'b1; w.MemW = 1'b1;
    checks++;
    if (observed() !== w) begin
      errors++;
      $display("FAIL str_memwrite_hold: got %h expected %h", observed(), w);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== zero_o()) begin
      errors++;
      $display("FAIL str_async_drop: got %h expected %h", observed(), zero_o());
    end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (observed() !== zero_o()) begin
      errors++;
      $display("FAIL str_reset_held: got %h expected %h", observed(), zero_o());
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    set_instr(2'b00, 6'b101101, 1'b1);
    build_instr(2'b00, 6'b101101, 1'b1, 1, 0);
    run_plan("post_reset_refetch", -1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.op = 2'b00;
    bus.funct = 6'b000000;
    bus.rd15 = 1'b0;
    test_reset();
    test_add();
    test_cmp();
    test_ldr();
    test_branch_illegal();
    test_latency();
    test_random();
    test_str_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
